// File: rtl/quad_pkg.sv
// Shared types and quadrature-sequence helpers for the encoder front end.
package quad_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  typedef enum logic {S_INIT, S_TRACK} qstate_t;

  // Forward rotation is 00 -> 01 -> 11 -> 10 -> 00
  function automatic phase_t fwd_next(input phase_t p);
    case (p)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

  function automatic phase_t fwd_prev(input phase_t p);
    case (p)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/glitch_filter.sv
// One encoder channel: metastability synchroniser followed by a stability counter
// that only lets a new level through after FILT_CYCLES consecutive stable cycles.
module glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic hold,
  input  logic load,
  output logic sync,
  output logic pre_sync,
  output logic filt
);

  localparam int CW = $clog2(FILT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign sync     = sync_q[SYNC_STAGES-1];
  assign pre_sync = sync_q[SYNC_STAGES-2];

  // load bypasses the counter so start-up can adopt the settled level directly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (load) begin
      cnt  <= '0;
      filt <= sync;
    end else if (hold || sync == filt) begin
      cnt  <= '0;
    end else if (cnt == CW'(FILT_CYCLES - 1)) begin
      cnt  <= '0;
      filt <= sync;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature front end: filters A/B, waits for a settled start-up phase, then emits
// one-cycle step strobes with direction and flags illegal double-bit transitions.
import quad_pkg::*;

module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       err_clr,
  output logic       step,
  output logic       up_down,
  output logic       err,
  output logic       ready,
  output logic [1:0] phase
);

  localparam int CW = $clog2(FILT_CYCLES + 1);

  qstate_t       state;
  logic [CW-1:0] settle_cnt;
  phase_t        p_q;
  logic          a_sync, b_sync, a_pre, b_pre, a_f, b_f;
  logic          hold, load, pair_stable, settle_done;
  phase_t        n_phase;
  logic          legal_up, legal_dn, illegal;

  glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_a (
    .clk(clk), .reset(reset), .raw(enc_a), .hold(hold), .load(load),
    .sync(a_sync), .pre_sync(a_pre), .filt(a_f)
  );

  glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_b (
    .clk(clk), .reset(reset), .raw(enc_b), .hold(hold), .load(load),
    .sync(b_sync), .pre_sync(b_pre), .filt(b_f)
  );

  // The penultimate stage is next cycle's sync value, so equality means "unchanged"
  assign pair_stable = ({a_pre, b_pre} == {a_sync, b_sync});
  assign settle_done = (settle_cnt == CW'(FILT_CYCLES - 1));
  assign hold        = (state == S_INIT);
  assign load        = hold && pair_stable && settle_done;

  assign n_phase  = {a_f, b_f};
  assign phase    = n_phase;
  assign legal_up = (n_phase == fwd_next(p_q));
  assign legal_dn = (n_phase == fwd_prev(p_q));
  assign illegal  = ((n_phase ^ p_q) == 2'b11);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_INIT;
      settle_cnt <= '0;
      p_q        <= PH_00;
      step       <= 1'b0;
      up_down    <= 1'b1;
      err        <= 1'b0;
      ready      <= 1'b0;
    end else begin
      step <= 1'b0;
      if (state == S_TRACK && illegal) err <= 1'b1;
      else if (err_clr)                err <= 1'b0;
      case (state)
        S_INIT: begin
          if (!pair_stable) begin
            settle_cnt <= '0;
          end else if (settle_done) begin
            settle_cnt <= '0;
            p_q        <= {a_sync, b_sync};
            ready      <= 1'b1;
            state      <= S_TRACK;
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end
        S_TRACK: begin
          // p follows n unconditionally so a disabled edge is never replayed later
          p_q <= n_phase;
          if ((legal_up || legal_dn) && enable) begin
            step    <= 1'b1;
            up_down <= legal_up;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed-vector bench for quad_step_decoder; expected step strobes are queued at
// stimulus time and a negedge monitor pops them as the DUT emits steps.
module tb_quad_step_decoder;

  localparam int LAT = 7;

  logic       clk = 1'b0;
  logic       reset, enable, enc_a, enc_b, err_clr;
  logic       step, up_down, err, ready;
  logic [1:0] phase;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int step_count = 0;
  int exp_cyc_q[$];
  bit exp_dir_q[$];

  quad_step_decoder #(.SYNC_STAGES(2), .FILT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .enc_a(enc_a), .enc_b(enc_b),
    .err_clr(err_clr), .step(step), .up_down(up_down), .err(err),
    .ready(ready), .phase(phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every step strobe must match the oldest queued expectation
  always @(negedge clk) begin : monitor
    int ec;
    bit ed;
    if (step === 1'b1) begin
      checks++;
      if (exp_cyc_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_step: step=1 at cycle %0d, required no step", cyc);
      end else begin
        ec = exp_cyc_q.pop_front();
        ed = exp_dir_q.pop_front();
        if (cyc != ec || up_down !== ed) begin
          errors++;
          $display("[TB] FAIL step_event: cycle=%0d up_down=%b, required cycle=%0d up_down=%b",
                   cyc, up_down, ec, ed);
        end
      end
      step_count += (up_down === 1'b1) ? 1 : -1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic b, input bit exp_step, input bit exp_dir);
    @(negedge clk);
    enc_a = a;
    enc_b = b;
    if (exp_step) begin
      exp_cyc_q.push_back(cyc + LAT);
      exp_dir_q.push_back(exp_dir);
    end
  endtask

  task automatic pulseErrClr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; enc_a = 1'b1; enc_b = 1'b1; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_step", step, 0);
    checkOutput("rst_up_down", up_down, 1);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_phase", phase, 0);

    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("settle_ready_early", ready, 0);
    @(negedge clk);
    checkOutput("settle_ready", ready, 1);
    checkOutput("settle_phase", phase, 3);
    checkOutput("settle_err", err, 0);

    // Both bits flip at once: 11 -> 00
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("illegal_err", err, 1);
    checkOutput("illegal_phase", phase, 0);
    pulseErrClr();
    checkOutput("err_clr", err, 0);

    // Forward rotation
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1); repeat (10) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1); repeat (10) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1); repeat (10) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1); repeat (10) @(negedge clk);
    checkOutput("fwd_count", step_count, 4);
    checkOutput("fwd_up_down", up_down, 1);
    checkOutput("fwd_phase", phase, 0);

    // Reverse rotation
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); repeat (10) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0); repeat (10) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); repeat (10) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0); repeat (10) @(negedge clk);
    checkOutput("rev_count", step_count, 0);
    checkOutput("rev_up_down", up_down, 0);

    // 3-cycle glitch on A must be swallowed, then a stable A edge is a down step
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    enc_a = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("glitch_phase", phase, 0);
    checkOutput("glitch_count", step_count, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); repeat (10) @(negedge clk);
    checkOutput("stable_a_phase", phase, 2);
    checkOutput("stable_a_up_down", up_down, 0);
    checkOutput("stable_a_count", step_count, -1);

    // Illegal 10 -> 01 with err_clr coinciding with the detection cycle
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (LAT - 1) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("err_priority", err, 1);
    checkOutput("err_priority_phase", phase, 1);
    repeat (3) @(negedge clk);
    checkOutput("err_sticky", err, 1);
    pulseErrClr();
    checkOutput("err_clr2", err, 0);

    // Disabled edges still move the phase but produce no step
    @(negedge clk);
    enable = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0); repeat (10) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); repeat (10) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); repeat (10) @(negedge clk);
    checkOutput("dis_phase", phase, 0);
    checkOutput("dis_up_down", up_down, 0);
    checkOutput("dis_count", step_count, -1);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("reen_count", step_count, -1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1); repeat (10) @(negedge clk);
    checkOutput("reen_step_count", step_count, 0);
    checkOutput("reen_up_down", up_down, 1);

    // Reset lands while a down step is on the output
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (LAT) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_step", step, 0);
    checkOutput("midrst_up_down", up_down, 1);
    checkOutput("midrst_ready", ready, 0);
    checkOutput("midrst_phase", phase, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("resettle_ready", ready, 1);
    checkOutput("resettle_phase", phase, 0);
    repeat (20) @(negedge clk);
    checkOutput("pending_steps", exp_cyc_q.size(), 0);
    checkOutput("final_count", step_count, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream front end for the up/down counter: conditions a two-phase quadrature encoder (A/B) and emits a one-cycle `step` strobe plus a direction level `up_down`.
- `step` drives the counter clock-enable; `up_down` drives its direction input.
- Provides metastability synchronisation, per-channel glitch filtering, a start-up settle phase and illegal-transition detection.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per channel (min 2).
- FILT_CYCLES, 4, consecutive stable cycles required before a filtered channel changes (min 1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = step generation allowed; 0 = phase still tracked, `step` forced low
- enc_a  in  1  raw encoder channel A (asynchronous to clk)
- enc_b  in  1  raw encoder channel B (asynchronous to clk)
- err_clr  in  1  clears sticky `err`
- step  out  1  one-cycle pulse per legal quadrature edge
- up_down  out  1  direction of last legal edge: 1 = up, 0 = down
- err  out  1  sticky illegal-transition flag
- ready  out  1  1 once start-up settle has completed
- phase  out  2  current filtered phase {a_f, b_f}

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-high. While reset is high, all registers clear.
  - step=0, up_down=1, err=0, ready=0, phase=2'b00.
  - Synchroniser flops = 0, filter counters = 0, FSM = S_INIT.
- Synchroniser: SYNC_STAGES flops per channel; only the last stage is used downstream.
- Glitch filter (per channel):
  - The counter increments while sync != filtered, and clears when sync == filtered.
  - When the count reaches FILT_CYCLES, filtered := sync and the counter clears.
  - A pulse shorter than FILT_CYCLES cycles never propagates.
- FSM states:
  - S_INIT: a settle counter increments while the {a,b} sync pair is unchanged cycle to cycle, and clears on any change. At FILT_CYCLES, both filtered bits are loaded directly from sync, ready=1, and the FSM moves to S_TRACK. No step and no err are produced in this state. Filters are held cleared.
  - S_TRACK: filters active; each cycle, new phase n is compared with previous registered phase p.
- Decode in S_TRACK:
  - Forward sequence is 00->01->11->10->00.
  - n == forward successor of p: legal up.
  - n == forward predecessor of p: legal down.
  - n == p: no event.
  - Both bits changed in the same cycle: illegal. Set err, no step, up_down unchanged, p := n.
- Outputs are registered:
  - On a legal event with enable=1, step=1 for exactly one cycle in the cycle after the filtered phase changes, with up_down updated in that same cycle.
  - With enable=0, step stays 0 and up_down holds.
  - p always tracks n, so re-asserting enable never produces a retroactive step.
- Latency, enc pin edge to step: SYNC_STAGES + FILT_CYCLES + 1 cycles (default 7).
- Max step rate: one per FILT_CYCLES+1 cycles.
- err: set has priority over err_clr in the same cycle; err_clr alone clears it next cycle.
- Reset mid-operation: immediate return to reset values and S_INIT; no step issued during or after the reset release until a real edge occurs in S_TRACK.

Decomposition:
- Package quad_pkg:
  - `typedef logic [1:0] phase_t`
  - constants PH_00, PH_01, PH_11, PH_10
  - `typedef enum {S_INIT, S_TRACK} qstate_t`
  - functions fwd_next(phase_t) and fwd_prev(phase_t)
- Sub-module glitch_filter (synchroniser + stability counter, one channel, params SYNC_STAGES/FILT_CYCLES), instantiated twice.

Test Plan:
- Reset with A=B=1 held, release -> ready=1 after 2+4 cycles, phase=2'b11, step never asserted, err=0.
- Forward 00->01->11->10->00, each phase held 10 cycles -> exactly 4 step pulses, each 1 cycle, each 7 cycles after its pin edge, up_down=1; downstream counter 0->4.
- Reverse 00->10->11->01->00 -> 4 step pulses, up_down=0 from the first; downstream counter 4->0.
- A glitch high for 3 cycles (FILT_CYCLES=4) -> no step, phase stays 2'b00; then a 4-cycle-stable A -> phase=2'b10, up_down=0, one step.
- A and B toggled in the same cycle, 00->11 -> err=1, step=0, phase=2'b11. Then err_clr pulse -> err=0. err_clr asserted in the same cycle as a new illegal edge -> err stays 1.
- enable=0 during 3 forward edges -> no steps, phase tracks. Re-enable -> no step until the next edge, then one step. Assert reset mid-sequence -> step=0, up_down=1, ready=0 immediately.
